// File: rtl/llc_mem_responder.sv
// Memory-side responder for the LLC memory port: line-granular store with a
// fixed, programmable read latency and a single outstanding read.
`timescale 1ns/1ps
module llc_mem_responder #(
    parameter int LINE_BITS  = 128,
    parameter int ADDR_BITS  = 28,
    parameter int HPROT_BITS = 2,
    parameter int MEM_LINES  = 256,
    parameter int RD_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  llc_mem_req_valid,
    output logic                  llc_mem_req_ready,
    input  logic                  llc_mem_req_hwrite,
    input  logic [ADDR_BITS-1:0]  llc_mem_req_addr,
    input  logic [HPROT_BITS-1:0] llc_mem_req_hprot,
    input  logic [LINE_BITS-1:0]  llc_mem_req_line,
    output logic                  llc_mem_rsp_valid,
    input  logic                  llc_mem_rsp_ready,
    output logic [LINE_BITS-1:0]  llc_mem_rsp_line,
    output logic                  init_done,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);

    localparam int IDX_BITS = $clog2(MEM_LINES);
    localparam int CNT_BITS = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_READ_WAIT,
        ST_RESP
    } state_t;

    state_t               r_state;
    logic [LINE_BITS-1:0] r_mem [MEM_LINES];
    logic [IDX_BITS-1:0]  r_init_idx;
    logic [IDX_BITS-1:0]  r_rd_idx;
    logic [CNT_BITS-1:0]  r_lat_cnt;
    logic                 r_req_ready;
    logic                 r_rsp_valid;
    logic [LINE_BITS-1:0] r_rsp_line;
    logic                 r_init_done;
    logic [15:0]          r_rd_count;
    logic [15:0]          r_wr_count;

    logic                 w_accept;
    logic                 w_wr_accept;
    logic [IDX_BITS-1:0]  w_idx;
    logic                 w_unused;

    // Ready is only ever high in IDLE, so it doubles as the IDLE qualifier.
    assign w_accept    = llc_mem_req_valid & r_req_ready;
    assign w_wr_accept = w_accept & llc_mem_req_hwrite;
    assign w_idx       = llc_mem_req_addr[IDX_BITS-1:0];
    // Upper address bits alias by design; hprot has no effect on the store.
    assign w_unused    = &{1'b0, llc_mem_req_hprot, llc_mem_req_addr[ADDR_BITS-1:IDX_BITS]};

    // NOTE: the array has no reset branch; the INIT walk clears it one line per cycle,
    // which keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (r_state == ST_INIT) begin
                r_mem[r_init_idx] <= '0;
            end else if (w_wr_accept) begin
                r_mem[w_idx] <= llc_mem_req_line;
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_INIT;
            r_init_idx  <= '0;
            r_rd_idx    <= '0;
            r_lat_cnt   <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_line  <= '0;
            r_init_done <= 1'b0;
            r_rd_count  <= '0;
            r_wr_count  <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_idx <= r_init_idx + 1'b1;
                    if (r_init_idx == IDX_BITS'(MEM_LINES - 1)) begin
                        r_state     <= ST_IDLE;
                        r_init_done <= 1'b1;
                        r_req_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (w_wr_accept) begin
                        r_wr_count <= r_wr_count + 16'd1;
                    end else if (w_accept) begin
                        r_rd_idx    <= w_idx;
                        r_lat_cnt   <= CNT_BITS'(RD_LATENCY - 1);
                        r_req_ready <= 1'b0;
                        r_state     <= ST_READ_WAIT;
                    end
                end
                ST_READ_WAIT: begin
                    if (r_lat_cnt == '0) begin
                        r_rsp_line  <= r_mem[r_rd_idx];
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (llc_mem_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rd_count  <= r_rd_count + 16'd1;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign llc_mem_req_ready = r_req_ready;
    assign llc_mem_rsp_valid = r_rsp_valid;
    assign llc_mem_rsp_line  = r_rsp_line;
    assign init_done         = r_init_done;
    assign rd_count          = r_rd_count;
    assign wr_count          = r_wr_count;

endmodule
